// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM microphone peripheral.
package pdm_pkg;

    // PCM sample width produced by the CIC3 decimator.
    localparam int unsigned PCM_W              = 16;
    // Default number of buffered PCM samples.
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    // Bus register offsets of the peripheral.
    localparam logic [7:0] REG_PCM_DATA    = 8'h08;
    localparam logic [7:0] REG_FIFO_STATUS = 8'h10;
    localparam logic [7:0] REG_WATERMARK   = 8'h14;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pdm_fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module pdm_fifo_mem
    import pdm_pkg::*;
#(
    parameter int unsigned DATA_W = PCM_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pdm_pcm_fifo.sv
// PCM sample FIFO between the decimator and the bus-facing PCM register, with fill
// level, watermark interrupt and sticky overflow flag.
module pdm_pcm_fifo
    import pdm_pkg::*;
#(
    parameter int unsigned DATA_W = PCM_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W:0]   watermark,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    output logic              wm_irq
);

    localparam int unsigned LVL_W   = ADDR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              wm_irq_q, wm_irq_d;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] rd_data;

    assign out_valid = (level_q != '0);
    assign full      = (level_q == DEPTH_LVL);

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign pop_ok  = pop && out_valid && !clear;
    assign push_ok = in_valid && (!full || pop_ok) && !clear;

    // Next-state for pointers, level, overflow and watermark interrupt.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
            if (in_valid && !push_ok) begin
                overflow_d = 1'b1;
            end
        end
        // Registered so the interrupt moves on the same edge as level.
        wm_irq_d = (watermark != '0) && (level_d >= watermark);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            wm_irq_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            wm_irq_q   <= wm_irq_d;
        end
    end

    pdm_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign out_data = out_valid ? rd_data : '0;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign wm_irq   = wm_irq_q;

endmodule

// File: tb/tb_pdm_pcm_fifo.sv
// Self-checking bench for pdm_pcm_fifo: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pdm_pcm_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        pop;
    logic        clear;
    logic [3:0]  watermark;
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
    logic        wm_irq;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        pp;
        logic        clr;
        logic [3:0]  wm;
        logic [3:0]  lvl;
        logic        vld;
        logic [15:0] od;
        logic        fl;
        logic        ovf;
        logic        irq;
    } vec_t;

    vec_t tbl [16];

    // Reference model state
    int m_q [$];
    bit m_ovf;
    bit m_irq;

    pdm_pcm_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .pop       (pop),
        .clear     (clear),
        .watermark (watermark),
        .out_data  (out_data),
        .out_valid (out_valid),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .wm_irq    (wm_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_lvl, input logic e_vld,
                             input logic [15:0] e_od, input logic e_full, input logic e_ovf,
                             input logic e_irq);
        chk({tag, ".level"},     32'(level),     32'(e_lvl));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
        chk({tag, ".out_data"},  32'(out_data),  32'(e_od));
        chk({tag, ".full"},      32'(full),      32'(e_full));
        chk({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
        chk({tag, ".wm_irq"},    32'(wm_irq),    32'(e_irq));
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic iv, input logic [15:0] d, input logic pp, input logic clr);
        in_valid = iv;
        in_data  = d;
        pop      = pp;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pop      = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        int exp_seq [8];
        logic iv, pp, clr, rs;
        logic [15:0] d;

        // Directed vectors: fields iv, data, pop, clear, watermark, then expected outputs.
        tbl[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd2, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0A01, 1'b0, 1'b0, 4'd4, 4'd1, 1'b1, 16'h0A01, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h0A02, 1'b0, 1'b0, 4'd4, 4'd2, 1'b1, 16'h0A01, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0A03, 1'b0, 1'b0, 4'd4, 4'd3, 1'b1, 16'h0A01, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 16'h0A04, 1'b0, 1'b0, 4'd4, 4'd4, 1'b1, 16'h0A01, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd4, 4'd3, 1'b1, 16'h0A02, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd3, 1'b1, 16'h0A02, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd3, 4'd3, 1'b1, 16'h0A02, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 16'h0A05, 1'b1, 1'b0, 4'd3, 4'd3, 1'b1, 16'h0A03, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        pop       = 1'b0;
        clear     = 1'b0;
        watermark = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check_all("idle", 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            watermark = tbl[i].wm;
            cyc(tbl[i].iv, tbl[i].d, tbl[i].pp, tbl[i].clr);
            check_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].vld, tbl[i].od, tbl[i].fl,
                      tbl[i].ovf, tbl[i].irq);
        end
        watermark = 4'd0;

        // Overflow: ninth push is dropped; watermark boundaries on a full FIFO.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        check_all("ovf.full8", 4'd8, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0009, 1'b0, 1'b0);
        check_all("ovf.push9", 4'd8, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
        watermark = 4'd9;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check_all("ovf.wm9", 4'd8, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
        watermark = 4'd8;
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check_all("ovf.wm8", 4'd8, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1);
        watermark = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            check_all($sformatf("ovf.drain%0d", i), 4'(8 - i), (i < 8),
                      (i < 8) ? 16'(i + 1) : 16'h0, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        check_all("ovf.clear", 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Push and pop together while full: accepted, no overflow.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'hAAAA, 1'b1, 1'b0);
        check_all("pp_full", 4'd8, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        exp_seq = '{2, 3, 4, 5, 6, 7, 8, 'hAAAA};
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            check_all($sformatf("pp_full.drain%0d", k), 4'(8 - k), (k < 8),
                      (k < 8) ? 16'(exp_seq[k]) : 16'h0, 1'b0, 1'b0, 1'b0);
        end

        // Clear beats a simultaneous push and pop.
        for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        check_all("clr.pre", 4'd5, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 16'h1234, 1'b1, 1'b1);
        check_all("clr.hit", 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h5A5A, 1'b0, 1'b0);
        check_all("clr.push", 4'd1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation discards stored samples.
        cyc(1'b1, 16'h7777, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 16'h8888, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_all("midrst", 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the queue model.
        m_q.delete();
        m_ovf = 1'b0;
        m_irq = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) watermark = 4'($urandom_range(0, 15));
            iv  = ($urandom_range(0, 9) < 6);
            pp  = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 49) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            d   = 16'($urandom);
            rst_n = !rs;
            cyc(iv, d, pp, clr);
            rst_n = 1'b1;
            if (rs || clr) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                bit did_pop;
                did_pop = pp && (m_q.size() > 0);
                if (did_pop) void'(m_q.pop_front());
                if (iv) begin
                    if (m_q.size() < DEPTH) m_q.push_back(int'(d));
                    else m_ovf = 1'b1;
                end
            end
            m_irq = !rs && (watermark != 0) && (m_q.size() >= int'(watermark));
            check_all($sformatf("rnd%0d", n), 4'(m_q.size()), (m_q.size() > 0),
                      (m_q.size() > 0) ? 16'(m_q[0]) : 16'h0, (m_q.size() == DEPTH),
                      m_ovf, m_irq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
